// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer
// Paces a six-phase hue-wheel fade for the on-board RGB LED. A cycle-count
// step timer (or a manual single_step while paused) produces step events.
// Each event ramps the one channel that belongs to the current phase.
// Every register is clocked by clk.
//
// Optional feature: define RGB_HUE_PWM_OUT_EN to compile in the PWM
// comparators that drive led_r/led_g/led_b. Without it those pins are tied
// to 0.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   enable         1 = step timer runs, 0 = timer and wheel hold
//   single_step    one-cycle pulse, one immediate step (only while enable=0)
//   duty_r/g/b     current PWM duty per channel (0..PWM_INTERVAL)
//   phase          hue phase 0..5
//   step_idx       step index within the phase
//   wrap           one-cycle pulse when phase 5 completes
//   led_r/g/b      PWM pin outputs
module rgb_hue_sequencer #(
  parameter int unsigned STEP_INTERVAL   = 2000000,
  parameter int unsigned STEPS_PER_PHASE = 6,
  parameter int unsigned PWM_INTERVAL    = 1200,
  parameter int unsigned STEP_VAL        = PWM_INTERVAL / STEPS_PER_PHASE,
  parameter int unsigned DW              = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 single_step,
  output logic [DW-1:0]                        duty_r,
  output logic [DW-1:0]                        duty_g,
  output logic [DW-1:0]                        duty_b,
  output logic [2:0]                           phase,
  output logic [$clog2(STEPS_PER_PHASE+1)-1:0] step_idx,
  output logic                                 wrap,
  output logic                                 led_r,
  output logic                                 led_g,
  output logic                                 led_b
);

  localparam int unsigned TW = $clog2(STEP_INTERVAL + 1);
  localparam int unsigned SW = $clog2(STEPS_PER_PHASE + 1);

  localparam logic [DW-1:0] FULL   = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] DSTEP  = DW'(STEP_VAL);
  localparam logic [TW-1:0] T_LAST = TW'(STEP_INTERVAL - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STEPS_PER_PHASE - 1);

  // Phase names carry the channel being ramped and its direction.
  typedef enum logic [2:0] {
    PH_G_UP = 3'd0,
    PH_R_DN = 3'd1,
    PH_B_UP = 3'd2,
    PH_G_DN = 3'd3,
    PH_R_UP = 3'd4,
    PH_B_DN = 3'd5
  } phase_e;

  phase_e        phase_q;
  logic [TW-1:0] timer_q;
  logic          step_evt;
  logic          last_step;

  // A manual step is only accepted while paused, so it can never collide
  // with a timer step.
  always_comb begin
    step_evt  = enable ? (timer_q == T_LAST) : single_step;
    last_step = (step_idx == S_LAST);
  end

  assign phase = phase_q;

  // Step timer, duty ramps and hue-wheel phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      phase_q  <= PH_G_UP;
      step_idx <= '0;
      wrap     <= 1'b0;
      duty_r   <= FULL;
      duty_g   <= '0;
      duty_b   <= '0;
    end else begin
      wrap <= 1'b0;
      if (enable) begin
        timer_q <= (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
      end
      if (step_evt) begin
        // The final step of a phase lands exactly on the endpoint, which
        // absorbs the integer-divide remainder of STEP_VAL.
        case (phase_q)
          PH_G_UP: duty_g <= last_step ? FULL : duty_g + DSTEP;
          PH_R_DN: duty_r <= last_step ? '0   : duty_r - DSTEP;
          PH_B_UP: duty_b <= last_step ? FULL : duty_b + DSTEP;
          PH_G_DN: duty_g <= last_step ? '0   : duty_g - DSTEP;
          PH_R_UP: duty_r <= last_step ? FULL : duty_r + DSTEP;
          PH_B_DN: duty_b <= last_step ? '0   : duty_b - DSTEP;
          default: ;
        endcase
        if (last_step) begin
          step_idx <= '0;
          if (phase_q == PH_B_DN) begin
            phase_q <= PH_G_UP;
            wrap    <= 1'b1;
          end else begin
            phase_q <= phase_e'(phase_q + 3'd1);
          end
        end else begin
          step_idx <= step_idx + SW'(1);
        end
      end
    end
  end

`ifdef RGB_HUE_PWM_OUT_EN
  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);

  logic [DW-1:0] pwm_cnt;
  logic [DW-1:0] shd_r;
  logic [DW-1:0] shd_g;
  logic [DW-1:0] shd_b;

  // Free-running PWM period with duties shadowed at period start. At the
  // start cycle itself the freshly latched duty is compared directly so
  // the new value governs the whole period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      shd_r   <= '0;
      shd_g   <= '0;
      shd_b   <= '0;
      led_r   <= 1'b0;
      led_g   <= 1'b0;
      led_b   <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + DW'(1);
      if (pwm_cnt == '0) begin
        shd_r <= duty_r;
        shd_g <= duty_g;
        shd_b <= duty_b;
        led_r <= (duty_r != '0);
        led_g <= (duty_g != '0);
        led_b <= (duty_b != '0);
      end else begin
        led_r <= (pwm_cnt < shd_r);
        led_g <= (pwm_cnt < shd_g);
        led_b <= (pwm_cnt < shd_b);
      end
    end
  end
`else
  assign led_r = 1'b0;
  assign led_g = 1'b0;
  assign led_b = 1'b0;
`endif

endmodule
